arc4_encrypt: RTL
=================

# arc4_encrypt

ARC4 encryptor that produces the length-prefixed ciphertext the key-cracking datapath consumes. Given a 24-bit key and a length-prefixed plaintext in an external single-port memory, it runs the ARC4 key schedule and keystream generator and writes the ciphertext into the external ciphertext memory using the same format. It is the writer side of the ct_mem format and uses the same en/rdy start handshake as crack.

## Interface
- No parameters. Key length is fixed at 3 bytes.
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  high when idle and able to accept en
- key  in  24  ARC4 key, latched on accepted en; key byte 0 = key[23:16], byte 1 = key[15:8], byte 2 = key[7:0]
- pt_addr  out  8  plaintext memory address
- pt_rddata  in  8  plaintext read data, valid 1 cycle after pt_addr
- ct_addr  out  8  ciphertext memory address
- ct_wrdata  out  8  ciphertext write data
- ct_wren  out  1  ciphertext write strobe, one byte per asserted cycle

## Operation
- Memory format, both sides: byte 0 = length L (0..255); bytes 1..L = payload.
- Accept: rdy=1 and en=1 at a posedge. rdy=0 from the next cycle. key is captured into an internal register. Later changes to key are ignored.
- en while rdy=0 is ignored, and no request is queued.
- INIT: S[i]=i for i=0..255.
- KSA: j=0. For i=0..255: j=(j+S[i]+key_byte[i mod 3]) mod 256, then swap S[i], S[j]. For the case i==j, the final S[i] must equal the old S[i].
- LEN: read pt[0], then write ct[0]=L.
- PRGA: i=j=0. For k=1..L: i=i+1, j=j+S[i], swap S[i],S[j], pad=S[(S[i]+S[j]) mod 256], ct[k]=pt[k] XOR pad. All index sums are 8-bit and wrap mod 256.
- DONE: rdy=1 and the block returns to IDLE.
- L=0: only ct[0]=0 is written, then DONE.
- L=255: ct[255] is the last write. The 8-bit address must not wrap to 0, so ct[0] is never rewritten.
- Exactly L+1 ct writes per job, to addresses 0..L, in ascending order, each written exactly once.
- The S array is internal. The ct memory is never read.
- States (arc4_pkg enum): IDLE, INIT, KSA, LEN, PRGA, DONE. KSA and PRGA may use internal sub-states for memory read/write sequencing.

## Timing
- Values on the cycle after a reset edge:
  - rdy=1, ct_wren=0, ct_addr=0, ct_wrdata=0, pt_addr=0
  - state=IDLE
- Reset wins over everything, including an in-flight job. Any S contents are discarded. No ct write occurs on the reset cycle or after it.
- Both the pt and S memories have 1-cycle registered read latency. A single S access port is allowed, either read or write per cycle.
- Throughput bounds:
  - INIT: at most 256 cycles
  - KSA: at most 6 cycles per i
  - PRGA: at most 8 cycles per byte
  - Total from accept to rdy=1: at most 256 + 1536 + 8·L + 8 cycles
- rdy rises on the cycle after the final ct write. en may be accepted on that same cycle.
- ct_wren is asserted for exactly one cycle per byte. ct_addr and ct_wrdata are stable in that cycle.
- While rdy=1, ct_wren must stay 0.

## Structure
- Package arc4_pkg contains:
  - the state enum
  - KEY_BYTES=3
  - an 8-bit byte_t typedef
- Sub-module s_mem holds the 256×8 single-port S array (address, wrdata, wren, rddata, 1-cycle read). It is inferable as block RAM.
- The top FSM owns the i/j/k counters, key register, L register and pad computation.

## Test plan
- Key 24'h4B6579 ("Key"), pt = length 9 followed by "Plaintext" → ct = 09 BB F3 16 E8 D9 40 AF 0A D3.
  - Check exactly 10 writes at addresses 0..9.
  - Check rdy returns high within the total-latency bound.
- L=0, any key → exactly one write, ct[0]=00. Then rdy=1.
- L=255 with random payload and random key → compare against a software ARC4 model.
  - Check 256 writes.
  - Check no write to address 0 after the first.
- Round trip: encrypt with key K, load the ct back as pt, encrypt again with K → output equals the original pt for 20 random keys and lengths.
- Assert rst_n=0 mid-PRGA → no ct_wren after reset. rdy=1 on the next cycle. A fresh job run afterwards produces the correct ct.
- Handshake robustness:
  - Toggle en and change key during a busy job → the output matches the originally latched key, and no second job starts.
  - Hold en=1 continuously → a back-to-back job starts on the cycle rdy rises.

Source files
------------

// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared types and constants for the ARC4 encryptor
package arc4_pkg;

  localparam int KEY_BYTES = 3;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA,
    LEN,
    PRGA,
    DONE
  } state_t;

  // Memory sequencing steps inside LEN, KSA and PRGA
  typedef enum logic [2:0] {
    PH_ADDR,
    PH_WAIT1,
    PH_IDX,
    PH_WAIT2,
    PH_PAD,
    PH_WR_I,
    PH_WR_J
  } phase_t;

  // Key byte 0 is the most significant byte of the 24-bit key
  function automatic byte_t key_byte(input logic [23:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    return key[23:16];
      2'd1:    return key[15:8];
      default: return key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/arc4_encrypt_s_mem.sv
// rtl/arc4_encrypt_s_mem.sv - 256x8 single-port S array with registered read
module s_mem
  import arc4_pkg::*;
(
  input  logic  clk,
  input  byte_t address,
  input  byte_t wrdata,
  input  logic  wren,
  output byte_t rddata
);

  byte_t mem [0:255];

  // One access per cycle; a write returns the old contents on rddata
  always_ff @(posedge clk) begin
    if (wren) begin
      mem[address] <= wrdata;
    end
    rddata <= mem[address];
  end

endmodule

// File: rtl/arc4_encrypt.sv
// rtl/arc4_encrypt.sv - ARC4 encryptor writing length-prefixed ciphertext
module arc4_encrypt
  import arc4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  pt_addr,
  input  logic [7:0]  pt_rddata,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren
);

  state_t      state;
  phase_t      phase;
  byte_t       i_q, j_q, k_q, len_q;
  byte_t       si_q, sj_q, t_q, pt_byte_q;
  logic [23:0] key_q;
  logic [1:0]  kidx_q;

  byte_t       s_addr, s_wrdata, s_rddata;
  logic        s_wren;

  byte_t       j_ksa, j_prga, t_idx, pad;

  s_mem u_s_mem (
    .clk     (clk),
    .address (s_addr),
    .wrdata  (s_wrdata),
    .wren    (s_wren),
    .rddata  (s_rddata)
  );

  // Index sums; the pad read is issued before the swap writes land, so a pad
  // index hitting i or j takes the swapped value instead of the stale read
  always_comb begin
    j_ksa  = j_q + s_rddata + key_byte(key_q, kidx_q);
    j_prga = j_q + s_rddata;
    t_idx  = si_q + s_rddata;
    if (t_q == i_q) begin
      pad = sj_q;
    end else if (t_q == j_q) begin
      pad = si_q;
    end else begin
      pad = s_rddata;
    end
  end

  // Main controller: job handshake, S init/schedule, keystream and ct writes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      phase     <= PH_ADDR;
      rdy       <= 1'b1;
      pt_addr   <= '0;
      ct_addr   <= '0;
      ct_wrdata <= '0;
      ct_wren   <= 1'b0;
      s_addr    <= '0;
      s_wrdata  <= '0;
      s_wren    <= 1'b0;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      len_q     <= '0;
      si_q      <= '0;
      sj_q      <= '0;
      t_q       <= '0;
      pt_byte_q <= '0;
      key_q     <= '0;
      kidx_q    <= '0;
    end else begin
      ct_wren <= 1'b0;
      s_wren  <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            key_q  <= key;
            rdy    <= 1'b0;
            i_q    <= '0;
            j_q    <= '0;
            kidx_q <= '0;
            state  <= INIT;
          end
        end

        INIT: begin
          s_addr   <= i_q;
          s_wrdata <= i_q;
          s_wren   <= 1'b1;
          i_q      <= i_q + 8'd1;
          if (i_q == 8'hFF) begin
            state <= KSA;
            phase <= PH_ADDR;
          end
        end

        KSA: begin
          case (phase)
            PH_ADDR: begin
              s_addr <= i_q;
              phase  <= PH_WAIT1;
            end
            PH_WAIT1: phase <= PH_IDX;
            PH_IDX: begin
              si_q   <= s_rddata;
              j_q    <= j_ksa;
              s_addr <= j_ksa;
              phase  <= PH_WAIT2;
            end
            PH_WAIT2: phase <= PH_WR_I;
            PH_WR_I: begin
              s_addr   <= i_q;
              s_wrdata <= s_rddata;
              s_wren   <= 1'b1;
              phase    <= PH_WR_J;
            end
            PH_WR_J: begin
              s_addr   <= j_q;
              s_wrdata <= si_q;
              s_wren   <= 1'b1;
              i_q      <= i_q + 8'd1;
              kidx_q   <= (kidx_q == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx_q + 2'd1;
              phase    <= PH_ADDR;
              if (i_q == 8'hFF) begin
                state <= LEN;
              end
            end
            default: phase <= PH_ADDR;
          endcase
        end

        LEN: begin
          case (phase)
            PH_ADDR: begin
              pt_addr <= '0;
              phase   <= PH_WAIT1;
            end
            PH_WAIT1: phase <= PH_IDX;
            PH_IDX: begin
              len_q     <= pt_rddata;
              ct_addr   <= '0;
              ct_wrdata <= pt_rddata;
              ct_wren   <= 1'b1;
              k_q       <= 8'd1;
              i_q       <= '0;
              j_q       <= '0;
              phase     <= PH_ADDR;
              state     <= (pt_rddata == 8'd0) ? DONE : PRGA;
            end
            default: phase <= PH_ADDR;
          endcase
        end

        PRGA: begin
          case (phase)
            PH_ADDR: begin
              i_q     <= i_q + 8'd1;
              s_addr  <= i_q + 8'd1;
              pt_addr <= k_q;
              phase   <= PH_WAIT1;
            end
            PH_WAIT1: phase <= PH_IDX;
            PH_IDX: begin
              si_q      <= s_rddata;
              j_q       <= j_prga;
              s_addr    <= j_prga;
              pt_byte_q <= pt_rddata;
              phase     <= PH_WAIT2;
            end
            PH_WAIT2: phase <= PH_PAD;
            PH_PAD: begin
              sj_q   <= s_rddata;
              t_q    <= t_idx;
              s_addr <= t_idx;
              phase  <= PH_WR_I;
            end
            PH_WR_I: begin
              s_addr   <= i_q;
              s_wrdata <= sj_q;
              s_wren   <= 1'b1;
              phase    <= PH_WR_J;
            end
            PH_WR_J: begin
              s_addr    <= j_q;
              s_wrdata  <= si_q;
              s_wren    <= 1'b1;
              ct_addr   <= k_q;
              ct_wrdata <= pt_byte_q ^ pad;
              ct_wren   <= 1'b1;
              phase     <= PH_ADDR;
              if (k_q == len_q) begin
                state <= DONE;
              end else begin
                k_q <= k_q + 8'd1;
              end
            end
            default: phase <= PH_ADDR;
          endcase
        end

        DONE: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
